load_aligner: RTL and testbench

Multi-cycle load data aligner and extender for the CPU memory stage. It takes a byte-addressed load request of size byte, half, word or (when XLEN=64) double, and issues one or two aligned reads to the data memory port. A second read is needed when the access crosses a word boundary. It then extracts the addressed bytes and returns them sign- or zero-extended to XLEN bits on a valid/ready response port.

---
 rtl/load_pkg.sv | 17 +
 rtl/load_extract.sv | 43 ++++
 rtl/load_aligner.sv | 116 +++++++++++
 tb/tb_load_aligner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared types and helpers for the load alignment path: access sizes, FSM states
// and the word-boundary crossing test.
package load_pkg;

    typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_D} size_e;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_e;

    // True when an access of 2**size bytes at byte offset off runs past a b-byte word.
    function automatic logic is_split(input logic [3:0] off, input logic [1:0] size,
                                      input logic [4:0] b);
        logic [4:0] n;
        n = 5'd1 << size;
        return ({1'b0, off} + n) > b;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte extractor: shifts the two-word assembly buffer down to the
// addressed byte and sign- or zero-extends the selected field to XLEN bits.
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] buffer,
    input  logic [2:0]        off,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [XLEN-1:0]   result
);

    logic [XLEN-1:0]    shifted;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] w32;

    always_comb begin
        shifted = XLEN'(buffer >> {off, 3'b000});
        b8      = shifted[7:0];
        h16     = shifted[15:0];
        w32     = shifted[31:0];
        result  = shifted;
        case (size_e'(size))
            SIZE_B: begin
                if (uns) result = XLEN'(shifted[7:0]);
                else     result = XLEN'(b8);
            end
            SIZE_H: begin
                if (uns) result = XLEN'(shifted[15:0]);
                else     result = XLEN'(h16);
            end
            SIZE_W: begin
                if (uns) result = XLEN'(shifted[31:0]);
                else     result = XLEN'(w32);
            end
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_aligner.sv
// Memory-stage load aligner: issues one or two aligned reads per load, assembles
// the bytes and returns the extended result on a valid/ready port.
module load_aligner
    import load_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN-1:0]       mem_rsp_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_data,
    output logic                  rsp_err
);

    localparam int B    = XLEN / 8;
    localparam int OFFW = $clog2(B);

    state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [2:0]            off_q;
    size_e                 size_q;
    logic                  uns_q;
    logic                  split_q;
    logic                  err_q;
    logic [2*XLEN-1:0]     buffer;
    logic [XLEN-1:0]       ext_data;
    logic                  illegal;

    assign illegal = (XLEN == 32) && (size_e'(req_size) == SIZE_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            base_q  <= '0;
            off_q   <= '0;
            size_q  <= SIZE_B;
            uns_q   <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            buffer  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                base_q  <= req_addr & ~ADDR_WIDTH'(B - 1);
                off_q   <= 3'(req_addr[OFFW-1:0]);
                size_q  <= size_e'(req_size);
                uns_q   <= req_unsigned;
                split_q <= is_split(4'(req_addr[OFFW-1:0]), req_size, 5'(B));
                err_q   <= illegal;
            end
            // First read fills the low word, the crossing read the high word.
            if (state == WAIT0 && mem_rsp_valid) buffer[XLEN-1:0] <= mem_rsp_data;
            if (state == WAIT1 && mem_rsp_valid) buffer[2*XLEN-1:XLEN] <= mem_rsp_data;
        end
    end

    load_extract #(.XLEN(XLEN)) u_extract (
        .buffer (buffer),
        .off    (off_q),
        .size   (size_q),
        .uns    (uns_q),
        .result (ext_data)
    );

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        rsp_valid     = 1'b0;
        rsp_err       = 1'b0;
        rsp_data      = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = illegal ? RESP : REQ0;
            end
            REQ0: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = base_q;
                if (mem_req_ready) state_nxt = WAIT0;
            end
            WAIT0: begin
                if (mem_rsp_valid) state_nxt = split_q ? REQ1 : RESP;
            end
            REQ1: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = base_q + ADDR_WIDTH'(B);
                if (mem_req_ready) state_nxt = WAIT1;
            end
            WAIT1: begin
                if (mem_rsp_valid) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_data  = err_q ? '0 : ext_data;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_aligner.sv
// Directed bench for load_aligner: an XLEN=32 and an XLEN=64 instance driven by a
// table of loads, plus backpressure and mid-access reset sequences.
module tb_load_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid32 = 1'b0, req_valid64 = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;
    logic        rsp_ready = 1'b0;
    logic        sel64 = 1'b0;

    logic        req_ready32, mem_req_valid32, rsp_valid32, rsp_err32;
    logic [31:0] mem_req_addr32, rsp_data32;
    logic        req_ready64, mem_req_valid64, rsp_valid64, rsp_err64;
    logic [31:0] mem_req_addr64;
    logic [63:0] rsp_data64;

    logic        rr_s, mrv_s, rv_s, re_s;
    logic [31:0] maddr_s;
    logic [63:0] rd_s;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_aligner #(.XLEN(32), .ADDR_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid32), .req_ready(req_ready32),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .mem_req_valid(mem_req_valid32), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr32), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data[31:0]), .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data32), .rsp_err(rsp_err32)
    );

    load_aligner #(.XLEN(64), .ADDR_WIDTH(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid64), .req_ready(req_ready64),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .mem_req_valid(mem_req_valid64), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr64), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data64), .rsp_err(rsp_err64)
    );

    assign rr_s    = sel64 ? req_ready64 : req_ready32;
    assign mrv_s   = sel64 ? mem_req_valid64 : mem_req_valid32;
    assign maddr_s = sel64 ? mem_req_addr64 : mem_req_addr32;
    assign rv_s    = sel64 ? rsp_valid64 : rsp_valid32;
    assign rd_s    = sel64 ? rsp_data64 : {32'h0, rsp_data32};
    assign re_s    = sel64 ? rsp_err64 : rsp_err32;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One load from request to response handshake. Memory returns w0 for the
    // first read and w1 for the second, one cycle after each read handshake.
    task automatic run_load(input bit x64, input logic [31:0] addr, input logic [1:0] size,
                            input bit uns, input logic [63:0] w0, input logic [63:0] w1,
                            input int mem_stall, input int rsp_stall, input bit stray,
                            output int nreads, output logic [31:0] a0, output logic [31:0] a1,
                            output int lat, output logic [63:0] data, output logic err);
        bit pend, req_on, rsp_on, done;
        logic [31:0] hold_addr;
        nreads = 0; a0 = '0; a1 = '0; lat = -1; data = '0; err = 1'b0;
        pend = 0; req_on = 0; rsp_on = 0; done = 0; hold_addr = '0;
        @(negedge clk);
        sel64 = x64; req_addr = addr; req_size = size; req_unsigned = uns;
        req_valid32 = !x64; req_valid64 = x64;
        mem_req_ready = 1'b0; rsp_ready = 1'b0; mem_rsp_valid = 1'b0;
        chk("req_ready_idle", 64'(rr_s), 64'd1);
        @(posedge clk);
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            req_valid32 = 1'b0; req_valid64 = 1'b0;
            mem_rsp_valid = pend;
            mem_rsp_data  = (nreads == 1) ? w0 : w1;
            if (stray && cyc == 2 && !pend) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 64'hDEADBEEF_DEADBEEF;
            end
            pend = 0;
            mem_req_ready = (cyc > mem_stall);
            chk($sformatf("req_ready_busy_c%0d", cyc), 64'(rr_s), 64'd0);
            if (mrv_s) begin
                if (!req_on) begin
                    req_on = 1; hold_addr = maddr_s;
                end else chk($sformatf("mem_addr_hold_c%0d", cyc), 64'(maddr_s), 64'(hold_addr));
                if (mem_req_ready) begin
                    nreads++;
                    if (nreads == 1) a0 = maddr_s; else a1 = maddr_s;
                    pend = 1; req_on = 0;
                end
            end
            if (rv_s) begin
                if (!rsp_on) begin
                    rsp_on = 1; lat = cyc; data = rd_s; err = re_s;
                end else begin
                    chk($sformatf("rsp_data_hold_c%0d", cyc), rd_s, data);
                    chk($sformatf("rsp_err_hold_c%0d", cyc), 64'(re_s), 64'(err));
                end
                rsp_ready = ((cyc - lat) >= rsp_stall);
                if (rsp_ready) done = 1;
            end else rsp_ready = 1'b0;
        end
        @(negedge clk);
        rsp_ready = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
        chk("rsp_valid_after", 64'(rv_s), 64'd0);
        chk("req_ready_after", 64'(rr_s), 64'd1);
    endtask

    typedef struct {
        bit          x64;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [63:0] w0, w1;
        logic [63:0] exp_data;
        bit          exp_err;
        int          exp_n;
        logic [31:0] exp_a0, exp_a1;
        int          exp_lat;
    } vec_t;

    vec_t vt[14];

    initial begin
        int          nr, lat;
        logic [31:0] a0, a1;
        logic [63:0] d;
        logic        e;

        vt[0]  = '{1'b0, 32'h1003, 2'd0, 1'b0, 64'h80123456, 64'h0, 64'hFFFFFF80, 1'b0, 1, 32'h1000, 32'h0, 3};
        vt[1]  = '{1'b0, 32'h1003, 2'd0, 1'b1, 64'h80123456, 64'h0, 64'h00000080, 1'b0, 1, 32'h1000, 32'h0, 3};
        vt[2]  = '{1'b0, 32'h1003, 2'd1, 1'b0, 64'hAABBCCDD, 64'h11223344, 64'h000044AA, 1'b0, 2, 32'h1000, 32'h1004, 5};
        vt[3]  = '{1'b0, 32'h1001, 2'd1, 1'b1, 64'hAABBCCDD, 64'h11223344, 64'h0000BBCC, 1'b0, 1, 32'h1000, 32'h0, 3};
        vt[4]  = '{1'b0, 32'h1002, 2'd1, 1'b0, 64'hAABBCCDD, 64'h0, 64'hFFFFAABB, 1'b0, 1, 32'h1000, 32'h0, 3};
        vt[5]  = '{1'b0, 32'h1000, 2'd0, 1'b1, 64'hAABBCCDD, 64'h0, 64'h000000DD, 1'b0, 1, 32'h1000, 32'h0, 3};
        vt[6]  = '{1'b0, 32'h1000, 2'd2, 1'b0, 64'hAABBCCDD, 64'h0, 64'hAABBCCDD, 1'b0, 1, 32'h1000, 32'h0, 3};
        vt[7]  = '{1'b0, 32'h1002, 2'd2, 1'b0, 64'hAABBCCDD, 64'h11223344, 64'h3344AABB, 1'b0, 2, 32'h1000, 32'h1004, 5};
        vt[8]  = '{1'b0, 32'hFFFFFFFE, 2'd2, 1'b0, 64'hAABBCCDD, 64'h11223344, 64'h3344AABB, 1'b0, 2, 32'hFFFFFFFC, 32'h0, 5};
        vt[9]  = '{1'b0, 32'h1000, 2'd3, 1'b0, 64'hAABBCCDD, 64'h0, 64'h0, 1'b1, 0, 32'h0, 32'h0, 1};
        vt[10] = '{1'b1, 32'h1004, 2'd3, 1'b0, 64'h8877665544332211, 64'h00FFEEDDCCBBAA99, 64'hCCBBAA9988776655, 1'b0, 2, 32'h1000, 32'h1008, 5};
        vt[11] = '{1'b1, 32'h1004, 2'd2, 1'b0, 64'h8877665544332211, 64'h0, 64'hFFFFFFFF88776655, 1'b0, 1, 32'h1000, 32'h0, 3};
        vt[12] = '{1'b1, 32'h1006, 2'd2, 1'b1, 64'h8877665544332211, 64'h00FFEEDDCCBBAA99, 64'h00000000AA998877, 1'b0, 2, 32'h1000, 32'h1008, 5};
        vt[13] = '{1'b1, 32'h1007, 2'd0, 1'b0, 64'h8877665544332211, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 1, 32'h1000, 32'h0, 3};

        // Reset state of both instances
        repeat (3) @(negedge clk);
        chk("rst_req_ready32", 64'(req_ready32), 64'd1);
        chk("rst_mem_req_valid32", 64'(mem_req_valid32), 64'd0);
        chk("rst_mem_req_addr32", 64'(mem_req_addr32), 64'd0);
        chk("rst_rsp_valid32", 64'(rsp_valid32), 64'd0);
        chk("rst_rsp_data32", 64'(rsp_data32), 64'd0);
        chk("rst_rsp_err32", 64'(rsp_err32), 64'd0);
        chk("rst_req_ready64", 64'(req_ready64), 64'd1);
        chk("rst_rsp_data64", rsp_data64, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_load(vt[i].x64, vt[i].addr, vt[i].size, vt[i].uns, vt[i].w0, vt[i].w1,
                     0, 0, 1'b0, nr, a0, a1, lat, d, e);
            chk($sformatf("v%0d_data", i), d, vt[i].exp_data);
            chk($sformatf("v%0d_err", i), 64'(e), 64'(vt[i].exp_err));
            chk($sformatf("v%0d_nreads", i), 64'(nr), 64'(vt[i].exp_n));
            chk($sformatf("v%0d_addr0", i), 64'(a0), 64'(vt[i].exp_a0));
            chk($sformatf("v%0d_addr1", i), 64'(a1), 64'(vt[i].exp_a1));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
        end

        // Backpressure on both ports with a stray memory response during REQ0
        run_load(1'b0, 32'h1002, 2'd2, 1'b0, 64'hAABBCCDD, 64'h11223344, 4, 3, 1'b1,
                 nr, a0, a1, lat, d, e);
        chk("bp_data", d, 64'h3344AABB);
        chk("bp_err", 64'(e), 64'd0);
        chk("bp_nreads", 64'(nr), 64'd2);
        chk("bp_addr0", 64'(a0), 64'h1000);
        chk("bp_addr1", 64'(a1), 64'h1004);
        chk("bp_latency", 64'(lat), 64'd9);

        // Reset asserted while waiting on the second read
        @(negedge clk);
        sel64 = 1'b0; req_addr = 32'h1002; req_size = 2'd2; req_unsigned = 1'b0;
        req_valid32 = 1'b1; mem_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid32 = 1'b0;
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hAABBCCDD;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("w1_mem_req_addr", 64'(mem_req_addr32), 64'h1004);
        @(negedge clk);
        chk("w1_mem_req_valid", 64'(mem_req_valid32), 64'd0);
        chk("w1_req_ready", 64'(req_ready32), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("ar_req_ready", 64'(req_ready32), 64'd1);
        chk("ar_mem_req_valid", 64'(mem_req_valid32), 64'd0);
        chk("ar_mem_req_addr", 64'(mem_req_addr32), 64'd0);
        chk("ar_rsp_valid", 64'(rsp_valid32), 64'd0);
        chk("ar_rsp_data", 64'(rsp_data32), 64'd0);
        chk("ar_rsp_err", 64'(rsp_err32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_req_ready = 1'b0;
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h11223344;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("ar_stray_rsp_valid_a", 64'(rsp_valid32), 64'd0);
        chk("ar_stray_req_ready", 64'(req_ready32), 64'd1);
        @(negedge clk);
        chk("ar_stray_rsp_valid_b", 64'(rsp_valid32), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
